// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, opcode-driven execute T3-T7, HALT until reset.
// Define CU_MULDIV_EN to enable the mul/div sequences; otherwise those opcodes behave as nop.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic [9:0]  out_sel,
  output logic [10:0] in_sel,
  output logic [12:0] alu_op,
  output logic [2:0]  gr_sel,
  output logic [3:0]  mem_ctl,
  output logic        con_reset,
  output logic        run
);

  // out_sel bit positions
  localparam int O_HI  = 9;
  localparam int O_LO  = 8;
  localparam int O_ZH  = 7;
  localparam int O_ZL  = 6;
  localparam int O_PC  = 5;
  localparam int O_MDR = 4;
  localparam int O_IN  = 3;
  localparam int O_C   = 2;
  localparam int O_R   = 1;
  localparam int O_BA  = 0;

  // in_sel bit positions
  localparam int I_HI   = 10;
  localparam int I_LO   = 9;
  localparam int I_PC   = 8;
  localparam int I_IR   = 7;
  localparam int I_Z    = 6;
  localparam int I_Y    = 5;
  localparam int I_MAR  = 4;
  localparam int I_MDR  = 3;
  localparam int I_CON  = 2;
  localparam int I_OUTP = 1;
  localparam int I_R    = 0;

  // alu_op bit positions (NEG=1, NOT=0 are never driven by this sequencer)
  localparam int A_AND  = 12;
  localparam int A_OR   = 11;
  localparam int A_ADD  = 10;
  localparam int A_SUB  = 9;
  localparam int A_MUL  = 8;
  localparam int A_DIV  = 7;
  localparam int A_SHR  = 6;
  localparam int A_SHRA = 5;
  localparam int A_SHL  = 4;
  localparam int A_ROR  = 3;
  localparam int A_ROL  = 2;

  localparam int G_A = 2;
  localparam int G_B = 1;
  localparam int G_C = 0;

  localparam int M_READ  = 3;
  localparam int M_INCPC = 2;
  localparam int M_RD    = 1;
  localparam int M_WR    = 0;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_RTYPE, C_IMM, C_MULDIV, C_BRX,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_t;

  typedef struct packed {
    logic [9:0]  o;
    logic [10:0] i;
    logic [12:0] a;
    logic [2:0]  g;
    logic [3:0]  m;
  } ctl_t;

  state_t      state, state_nxt;
  cls_t        cls;
  logic [12:0] op_sel;
  ctl_t        c;
  logic [4:0]  opcode;

  assign opcode = ir[31:27];

  // Operand fields are decoded by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  // Instruction class plus the ALU function used in its compute step.
  always_comb begin
    cls    = C_NOP;
    op_sel = '0;
    case (opcode)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b00011: begin cls = C_RTYPE; op_sel[A_ADD]  = 1'b1; end
      5'b00100: begin cls = C_RTYPE; op_sel[A_SUB]  = 1'b1; end
      5'b00101: begin cls = C_RTYPE; op_sel[A_AND]  = 1'b1; end
      5'b00110: begin cls = C_RTYPE; op_sel[A_OR]   = 1'b1; end
      5'b00111: begin cls = C_RTYPE; op_sel[A_SHR]  = 1'b1; end
      5'b01000: begin cls = C_RTYPE; op_sel[A_SHRA] = 1'b1; end
      5'b01001: begin cls = C_RTYPE; op_sel[A_SHL]  = 1'b1; end
      5'b01010: begin cls = C_RTYPE; op_sel[A_ROR]  = 1'b1; end
      5'b01011: begin cls = C_RTYPE; op_sel[A_ROL]  = 1'b1; end
      5'b01100: begin cls = C_IMM;   op_sel[A_ADD]  = 1'b1; end
      5'b01101: begin cls = C_IMM;   op_sel[A_AND]  = 1'b1; end
      5'b01110: begin cls = C_IMM;   op_sel[A_OR]   = 1'b1; end
`ifdef CU_MULDIV_EN
      5'b01111: begin cls = C_MULDIV; op_sel[A_MUL] = 1'b1; end
      5'b10000: begin cls = C_MULDIV; op_sel[A_DIV] = 1'b1; end
`else
      5'b01111, 5'b10000: begin
        cls           = C_NOP;
        op_sel[A_MUL] = 1'b0;
        op_sel[A_DIV] = 1'b0;
      end
`endif
      5'b10010: cls = C_BRX;
      5'b10011: cls = C_JR;
      5'b10101: cls = C_IN;
      5'b10110: cls = C_OUT;
      5'b10111: cls = C_MFHI;
      5'b11000: cls = C_MFLO;
      5'b11010: cls = C_HALT;
      default:  cls = C_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    c         = '0;
    state_nxt = state;
    con_reset = 1'b0;
    run       = 1'b1;
    case (state)
      S_RESET: begin
        con_reset = 1'b1;
        run       = 1'b0;
        state_nxt = S_T0;
      end
      S_T0: begin
        c.o[O_PC]    = 1'b1;
        c.i[I_MAR]   = 1'b1;
        c.i[I_PC]    = 1'b1;
        c.m[M_INCPC] = 1'b1;
        state_nxt    = S_T1;
      end
      S_T1: begin
        c.m[M_READ] = 1'b1;
        c.m[M_RD]   = 1'b1;
        c.i[I_MDR]  = 1'b1;
        state_nxt   = mem_ready ? S_T2 : S_T1;
      end
      S_T2: begin
        c.o[O_MDR] = 1'b1;
        c.i[I_IR]  = 1'b1;
        state_nxt  = S_T3;
      end
      S_T3: begin
        state_nxt = S_T0;
        case (cls)
          C_LD, C_LDI, C_ST: begin
            c.g[G_B]  = 1'b1;
            c.o[O_BA] = 1'b1;
            c.i[I_Y]  = 1'b1;
            state_nxt = S_T4;
          end
          C_RTYPE, C_IMM, C_MULDIV: begin
            c.g[G_B]  = 1'b1;
            c.o[O_R]  = 1'b1;
            c.i[I_Y]  = 1'b1;
            state_nxt = S_T4;
          end
          C_BRX: begin
            c.g[G_A]   = 1'b1;
            c.o[O_R]   = 1'b1;
            c.i[I_CON] = 1'b1;
            state_nxt  = S_T4;
          end
          C_JR: begin
            c.g[G_A]  = 1'b1;
            c.o[O_R]  = 1'b1;
            c.i[I_PC] = 1'b1;
          end
          C_IN: begin
            c.o[O_IN] = 1'b1;
            c.g[G_A]  = 1'b1;
            c.i[I_R]  = 1'b1;
          end
          C_OUT: begin
            c.g[G_A]    = 1'b1;
            c.o[O_R]    = 1'b1;
            c.i[I_OUTP] = 1'b1;
          end
          C_MFHI: begin
            c.o[O_HI] = 1'b1;
            c.g[G_A]  = 1'b1;
            c.i[I_R]  = 1'b1;
          end
          C_MFLO: begin
            c.o[O_LO] = 1'b1;
            c.g[G_A]  = 1'b1;
            c.i[I_R]  = 1'b1;
          end
          C_HALT:  state_nxt = S_HALT;
          default: state_nxt = S_T0;
        endcase
      end
      S_T4: begin
        state_nxt = S_T5;
        case (cls)
          C_LD, C_LDI, C_ST: begin
            c.o[O_C]     = 1'b1;
            c.a[A_ADD]   = 1'b1;
            c.i[I_Z]     = 1'b1;
          end
          C_RTYPE, C_MULDIV: begin
            c.g[G_C] = 1'b1;
            c.o[O_R] = 1'b1;
            c.a      = op_sel;
            c.i[I_Z] = 1'b1;
          end
          C_IMM: begin
            c.o[O_C] = 1'b1;
            c.a      = op_sel;
            c.i[I_Z] = 1'b1;
          end
          C_BRX: begin
            c.o[O_PC] = 1'b1;
            c.i[I_Y]  = 1'b1;
          end
          default: state_nxt = S_T0;
        endcase
      end
      S_T5: begin
        state_nxt = S_T0;
        case (cls)
          C_LD, C_ST: begin
            c.o[O_ZL]  = 1'b1;
            c.i[I_MAR] = 1'b1;
            state_nxt  = S_T6;
          end
          C_LDI, C_RTYPE, C_IMM: begin
            c.o[O_ZL] = 1'b1;
            c.g[G_A]  = 1'b1;
            c.i[I_R]  = 1'b1;
          end
          C_BRX: begin
            c.o[O_C]   = 1'b1;
            c.a[A_ADD] = 1'b1;
            c.i[I_Z]   = 1'b1;
            state_nxt  = S_T6;
          end
          C_MULDIV: begin
            c.o[O_ZL] = 1'b1;
            c.i[I_LO] = 1'b1;
            state_nxt = S_T6;
          end
          default: state_nxt = S_T0;
        endcase
      end
      S_T6: begin
        state_nxt = S_T0;
        case (cls)
          C_LD: begin
            c.m[M_READ] = 1'b1;
            c.m[M_RD]   = 1'b1;
            c.i[I_MDR]  = 1'b1;
            state_nxt   = mem_ready ? S_T7 : S_T6;
          end
          C_ST: begin
            c.g[G_A]   = 1'b1;
            c.o[O_R]   = 1'b1;
            c.i[I_MDR] = 1'b1;
            state_nxt  = S_T7;
          end
          // Branch not taken: PC already holds the fall-through address.
          C_BRX: begin
            c.o[O_ZL] = con_ff;
            c.i[I_PC] = con_ff;
          end
          C_MULDIV: begin
            c.o[O_ZH] = 1'b1;
            c.i[I_HI] = 1'b1;
          end
          default: state_nxt = S_T0;
        endcase
      end
      S_T7: begin
        state_nxt = S_T0;
        case (cls)
          C_LD: begin
            c.o[O_MDR] = 1'b1;
            c.g[G_A]   = 1'b1;
            c.i[I_R]   = 1'b1;
          end
          C_ST: begin
            c.m[M_WR] = 1'b1;
            state_nxt = mem_ready ? S_T0 : S_T7;
          end
          default: state_nxt = S_T0;
        endcase
      end
      S_HALT: begin
        run       = 1'b0;
        state_nxt = S_HALT;
      end
      default: begin
        run       = 1'b0;
        state_nxt = S_RESET;
      end
    endcase
  end

  assign out_sel = c.o;
  assign in_sel  = c.i;
  assign alu_op  = c.a;
  assign gr_sel  = c.g;
  assign mem_ctl = c.m;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed table, hand sequences, and
// randomized instructions checked against a per-instruction micro-step list model.
module tb_control_unit;

  // {out_sel[10], in_sel[11], alu_op[13], gr_sel[3], mem_ctl[4], con_reset, run}
  typedef logic [42:0] cw_t;

  typedef struct {
    logic [31:0] ir;
    logic        con;
    int          cycles;
    int          step;
    cw_t         word;
    string       name;
  } vec_t;

  bit          clk;
  logic        reset, con_ff, mem_ready;
  logic [31:0] ir;
  logic [9:0]  out_sel;
  logic [10:0] in_sel;
  logic [12:0] alu_op;
  logic [2:0]  gr_sel;
  logic [3:0]  mem_ctl;
  logic        con_reset, run;

  control_unit dut (
    .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .out_sel(out_sel), .in_sel(in_sel), .alu_op(alu_op), .gr_sel(gr_sel),
    .mem_ctl(mem_ctl), .con_reset(con_reset), .run(run)
  );

  always #5 clk = ~clk;

  int checks, failures;

  cw_t HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, Rout, BAout;
  cw_t HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUTin, Rin;
  cw_t A_AND, A_OR, A_ADD, A_SUB, A_SHR, A_SHRA, A_SHL, A_ROR, A_ROL;
`ifdef CU_MULDIV_EN
  cw_t A_MUL, A_DIV;
`endif
  cw_t Gra, Grb, Grc, Read, IncPC, RdMem, WrMem, CR, RUN, T0W;
  cw_t rop[0:8];

  cw_t exp_q[$];
  bit  wt_q[$];
  bit  exp_halt;
  vec_t vt[14];

  function automatic cw_t bitw(int b);
    cw_t c = '0;
    c[b] = 1'b1;
    return c;
  endfunction

  function automatic cw_t cur();
    return {out_sel, in_sel, alu_op, gr_sel, mem_ctl, con_reset, run};
  endfunction

  task automatic chk(input string nm, input cw_t e);
    cw_t a;
    a = cur();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, a, e);
    end
  endtask

  task automatic init_names();
    HIout = bitw(42); LOout = bitw(41); Zhighout = bitw(40); Zlowout = bitw(39);
    PCout = bitw(38); MDRout = bitw(37); INout = bitw(36); Cout = bitw(35);
    Rout = bitw(34); BAout = bitw(33);
    HIin = bitw(32); LOin = bitw(31); PCin = bitw(30); IRin = bitw(29); Zin = bitw(28);
    Yin = bitw(27); MARin = bitw(26); MDRin = bitw(25); CONin = bitw(24);
    OUTin = bitw(23); Rin = bitw(22);
    A_AND = bitw(21); A_OR = bitw(20); A_ADD = bitw(19); A_SUB = bitw(18);
    A_SHR = bitw(15); A_SHRA = bitw(14); A_SHL = bitw(13); A_ROR = bitw(12); A_ROL = bitw(11);
`ifdef CU_MULDIV_EN
    A_MUL = bitw(17); A_DIV = bitw(16);
`endif
    Gra = bitw(8); Grb = bitw(7); Grc = bitw(6);
    Read = bitw(5); IncPC = bitw(4); RdMem = bitw(3); WrMem = bitw(2);
    CR = bitw(1); RUN = bitw(0);
    T0W = PCout | MARin | IncPC | PCin | RUN;
    rop = '{A_ADD, A_SUB, A_AND, A_OR, A_SHR, A_SHRA, A_SHL, A_ROR, A_ROL};
  endtask

  task automatic push(input cw_t w, input bit wt);
    exp_q.push_back(w | RUN);
    wt_q.push_back(wt);
  endtask

  // Expected micro-step list for one instruction, fetch included; wt marks memory waits.
  task automatic model(input logic [4:0] op, input logic con);
    exp_q.delete();
    wt_q.delete();
    exp_halt = 1'b0;
    push(PCout | MARin | IncPC | PCin, 0);
    push(Read | RdMem | MDRin, 1);
    push(MDRout | IRin, 0);
    if (op <= 2) begin
      push(Grb | BAout | Yin, 0);
      push(Cout | A_ADD | Zin, 0);
      if (op == 1) push(Zlowout | Gra | Rin, 0);
      else         push(Zlowout | MARin, 0);
      if (op == 0) begin
        push(Read | RdMem | MDRin, 1);
        push(MDRout | Gra | Rin, 0);
      end else if (op == 2) begin
        push(Gra | Rout | MDRin, 0);
        push(WrMem, 1);
      end
    end else if (op <= 11) begin
      push(Grb | Rout | Yin, 0);
      push(Grc | Rout | rop[op - 3] | Zin, 0);
      push(Zlowout | Gra | Rin, 0);
    end else if (op <= 14) begin
      push(Grb | Rout | Yin, 0);
      push(Cout | (op == 12 ? A_ADD : op == 13 ? A_AND : A_OR) | Zin, 0);
      push(Zlowout | Gra | Rin, 0);
`ifdef CU_MULDIV_EN
    end else if (op == 15 || op == 16) begin
      push(Grb | Rout | Yin, 0);
      push(Grc | Rout | (op == 15 ? A_MUL : A_DIV) | Zin, 0);
      push(Zlowout | LOin, 0);
      push(Zhighout | HIin, 0);
`endif
    end else begin
      case (op)
        5'd18: begin
          push(Gra | Rout | CONin, 0);
          push(PCout | Yin, 0);
          push(Cout | A_ADD | Zin, 0);
          push(con ? (Zlowout | PCin) : '0, 0);
        end
        5'd19: push(Gra | Rout | PCin, 0);
        5'd21: push(INout | Gra | Rin, 0);
        5'd22: push(Gra | Rout | OUTin, 0);
        5'd23: push(HIout | Gra | Rin, 0);
        5'd24: push(LOout | Gra | Rin, 0);
        5'd26: begin push('0, 0); exp_halt = 1'b1; end
        default: push('0, 0);
      endcase
    end
  endtask

  // Walk the expected list from T0; t1w/mw = wait cycles for fetch / operand memory (-1 random).
  task automatic run_seq(input string nm, input int t1w, input int mw);
    for (int s = 0; s < exp_q.size(); s++) begin
      int n;
      n = 0;
      if (wt_q[s]) n = (s == 1) ? t1w : mw;
      if (n < 0) n = $urandom_range(0, 3);
      for (int k = 0; k <= n; k++) begin
        mem_ready = wt_q[s] ? (k == n) : 1'($urandom);
        chk($sformatf("%s_s%0d_w%0d", nm, s, k), exp_q[s]);
        @(negedge clk);
      end
    end
  endtask

  task automatic reset_pulse(input string nm);
    reset = 1'b0;
    @(negedge clk);
    chk({nm, "_reset"}, CR);
    reset = 1'b1;
    @(negedge clk);
    chk({nm, "_t0"}, T0W);
  endtask

  task automatic run_vec(input vec_t v);
    int  cnt;
    bit  done;
    ir = v.ir;
    con_ff = v.con;
    mem_ready = 1'b1;
    cnt = 0;
    done = 1'b0;
    while (!done) begin
      if (cnt == v.step) chk(v.name, v.word);
      @(negedge clk);
      cnt++;
      if (cur() === T0W || cnt >= 20) done = 1'b1;
    end
    chk_int({v.name, "_len"}, cnt, v.cycles);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    init_names();
    reset = 1'b0; ir = '0; con_ff = 1'b0; mem_ready = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", CR);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t0_after_reset", T0W);

    // ld with two wait cycles in T6, st, add, brx not-taken / taken
    ir = 32'h0100_0095; model(5'd0, 1'b0); run_seq("ld_wait2", 0, 2);
    ir = 32'h1080_001F; model(5'd2, 1'b0); run_seq("st", 0, 0);
    ir = 32'h1A92_0000; model(5'd3, 1'b0); run_seq("add", 1, 0);
    ir = 32'h9000_0000; con_ff = 1'b0; model(5'd18, 1'b0); run_seq("brx_c0", 0, 0);
    con_ff = 1'b1; model(5'd18, 1'b1); run_seq("brx_c1", 0, 0);
    chk("seq_end_t0", T0W);

    vt[0]  = '{32'h0100_0095, 1'b0, 8, 6, Read | RdMem | MDRin | RUN, "v_ld_t6"};
    vt[1]  = '{32'h0800_0000, 1'b0, 6, 5, Zlowout | Gra | Rin | RUN, "v_ldi_t5"};
    vt[2]  = '{32'h1080_001F, 1'b0, 8, 7, WrMem | RUN, "v_st_t7"};
    vt[3]  = '{32'h1A92_0000, 1'b0, 6, 4, Grc | Rout | A_ADD | Zin | RUN, "v_add_t4"};
    vt[4]  = '{32'h2000_0000, 1'b0, 6, 4, Grc | Rout | A_SUB | Zin | RUN, "v_sub_t4"};
    vt[5]  = '{32'h5800_0000, 1'b0, 6, 4, Grc | Rout | A_ROL | Zin | RUN, "v_rol_t4"};
    vt[6]  = '{32'h6800_0000, 1'b0, 6, 4, Cout | A_AND | Zin | RUN, "v_andi_t4"};
    vt[7]  = '{32'h9000_0000, 1'b0, 7, 6, RUN, "v_brx0_t6"};
    vt[8]  = '{32'h9000_0000, 1'b1, 7, 6, Zlowout | PCin | RUN, "v_brx1_t6"};
    vt[9]  = '{32'h9800_0000, 1'b0, 4, 3, Gra | Rout | PCin | RUN, "v_jr_t3"};
    vt[10] = '{32'hB800_0000, 1'b0, 4, 3, HIout | Gra | Rin | RUN, "v_mfhi_t3"};
`ifdef CU_MULDIV_EN
    vt[11] = '{32'h7800_0000, 1'b0, 7, 4, Grc | Rout | A_MUL | Zin | RUN, "v_mul_t4"};
`else
    vt[11] = '{32'h7800_0000, 1'b0, 4, 3, RUN, "v_mul_nop"};
`endif
    vt[12] = '{32'hF800_0000, 1'b0, 4, 3, RUN, "v_undef_t3"};
    vt[13] = '{32'hB000_0000, 1'b0, 4, 3, Gra | Rout | OUTin | RUN, "v_out_t3"};
    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // Reset during the ld operand wait, then during the fetch wait
    ir = 32'h0100_0095; mem_ready = 1'b1;
    repeat (6) @(negedge clk);
    mem_ready = 1'b0;
    chk("ld_t6_wait", Read | RdMem | MDRin | RUN);
    reset_pulse("mid_ld");
    @(negedge clk);
    chk("t1_wait", Read | RdMem | MDRin | RUN);
    reset_pulse("mid_fetch");

    // Halt: stays put with run low until reset
    ir = 32'hD000_0000; model(5'd26, 1'b0); run_seq("halt", 0, 0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halt_c%0d", i), '0);
      mem_ready = 1'($urandom);
      @(negedge clk);
    end
    reset_pulse("halt");

    for (int r = 0; r < 60; r++) begin
      logic [4:0] op;
      logic       con;
      op  = 5'($urandom_range(0, 31));
      con = 1'($urandom);
      ir = {op, 27'($urandom)};
      con_ff = con;
      model(op, con);
      run_seq($sformatf("rnd%0d_op%0d", r, op), -1, -1);
      if (exp_halt) begin
        repeat (3) begin
          chk($sformatf("rnd%0d_halted", r), '0);
          @(negedge clk);
        end
        reset_pulse($sformatf("rnd%0d", r));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
